osc_dt_req: RTL and testbench

Requester-side endpoint of the emulator timestep protocol. It models one emulated oscillator, such as the TX or RX clock source. Each emu_clk cycle it publishes dt_req, the emulated time until its next edge, and consumes the globally agreed emu_dt that the time manager broadcasts (the minimum over all requesters). When the granted step reaches its edge, it toggles its emulated clock, raises cke for the edge cycle, and reloads the half-period.

---
 rtl/osc_dt_req_if.sv | 23 ++
 rtl/osc_dt_req.sv | 69 ++++++
 tb/tb_osc_dt_req.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/osc_dt_req_if.sv
// Timestep handshake between one oscillator requester and the time manager.
// The time manager drives emu_dt; the requester drives dt_req and cke.
interface osc_dt_req_if #(
  parameter int unsigned DT_WIDTH = 27
);
  logic [DT_WIDTH-1:0] emu_dt;
  logic [DT_WIDTH-1:0] dt_req;
  logic                cke;

  // Time manager side
  modport master (
    output emu_dt,
    input  dt_req,
    input  cke
  );

  // Oscillator (requester) side
  modport slave (
    input  emu_dt,
    output dt_req,
    output cke
  );
endinterface

// File: rtl/osc_dt_req.sv
// Requester endpoint of the emulator timestep protocol: models one emulated
// oscillator, publishes the time to its next edge and consumes the granted step.
module osc_dt_req #(
  parameter int unsigned          DT_WIDTH  = 27,
  parameter int unsigned          CNT_WIDTH = 32,
  parameter logic [DT_WIDTH-1:0]  DT_IDLE   = '1
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  osc_dt_req_if.slave          ts,
  input  logic                 en,
  input  logic [DT_WIDTH-1:0]  t_hi,
  input  logic [DT_WIDTH-1:0]  t_lo,
  output logic                 clk_val,
  output logic [CNT_WIDTH-1:0] edge_cnt,
  output logic                 err
);

  logic [DT_WIDTH-1:0]  r_time_left;
  logic                 r_clk_val;
  logic [CNT_WIDTH-1:0] r_edge_cnt;
  logic                 r_err;

  logic [DT_WIDTH-1:0]  w_hp_hi;
  logic [DT_WIDTH-1:0]  w_hp_lo;
  logic                 w_reach;
  logic                 w_over;

  // Half-periods clamped to at least one tick so a zero step is never requested
  always_comb begin
    w_hp_hi = (t_hi == '0) ? DT_WIDTH'(1) : t_hi;
    w_hp_lo = (t_lo == '0) ? DT_WIDTH'(1) : t_lo;
    w_reach = (ts.emu_dt >= r_time_left);
    w_over  = (ts.emu_dt >  r_time_left);
  end

  assign ts.dt_req = en ? r_time_left : DT_IDLE;
  assign ts.cke    = en & ~emu_rst & w_reach;
  assign clk_val   = r_clk_val;
  assign edge_cnt  = r_edge_cnt;
  assign err       = r_err;

  // Advance emulated time; toggle and reload on reaching (or overshooting) the edge
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      r_clk_val   <= 1'b0;
      r_time_left <= w_hp_lo;
      r_edge_cnt  <= '0;
      r_err       <= 1'b0;
    end else if (en) begin
      if (w_reach) begin
        // Overshoot is flagged but otherwise treated as an exact hit and discarded
        if (w_over) begin
          r_err <= 1'b1;
        end
        r_clk_val <= ~r_clk_val;
        if (!r_clk_val) begin
          r_time_left <= w_hp_hi;
          r_edge_cnt  <= r_edge_cnt + CNT_WIDTH'(1);
        end else begin
          r_time_left <= w_hp_lo;
        end
      end else begin
        r_time_left <= r_time_left - ts.emu_dt;
      end
    end
  end

endmodule

// File: tb/tb_osc_dt_req.sv
// Self-checking bench for osc_dt_req using a behavioural model and a scoreboard queue.
module tb_osc_dt_req;

  localparam int unsigned DTW  = 27;
  localparam int unsigned CW   = 32;
  localparam logic [DTW-1:0] IDLE = 27'h7FF_FFFF;

  typedef struct packed {
    logic [DTW-1:0] dt_req;
    logic           clk_val;
    logic [CW-1:0]  edge_cnt;
    logic           err;
  } exp_t;

  logic           emu_clk;
  logic           emu_rst;
  logic           en;
  logic [DTW-1:0] t_hi;
  logic [DTW-1:0] t_lo;
  logic           clk_val;
  logic [CW-1:0]  edge_cnt;
  logic           err;

  osc_dt_req_if #(.DT_WIDTH(DTW)) ts ();

  osc_dt_req #(
    .DT_WIDTH (DTW),
    .CNT_WIDTH(CW)
  ) dut (
    .emu_clk (emu_clk),
    .emu_rst (emu_rst),
    .ts      (ts),
    .en      (en),
    .t_hi    (t_hi),
    .t_lo    (t_lo),
    .clk_val (clk_val),
    .edge_cnt(edge_cnt),
    .err     (err)
  );

  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Behavioural model state
  logic [DTW-1:0] m_tl;
  logic           m_cv;
  logic [CW-1:0]  m_cnt;
  logic           m_er;

  function automatic logic [DTW-1:0] hp(input logic [DTW-1:0] x);
    return (x == '0) ? 27'd1 : x;
  endfunction

  // One emu_clk cycle: drive inputs, check cke, predict next state, compare after the edge
  task automatic step(input bit r, input bit e, input logic [DTW-1:0] dt);
    exp_t ex;
    exp_t got;
    logic exp_cke;
    emu_rst   = r;
    en        = e;
    ts.emu_dt = dt;
    #1;
    exp_cke = e & ~r & (dt >= m_tl);
    n_tests++;
    if (ts.cke !== exp_cke) begin
      n_fail++;
      $display("FAIL cke: got %0b expected %0b (dt=%0d tl=%0d)", ts.cke, exp_cke, dt, m_tl);
    end
    if (r) begin
      m_cv = 1'b0; m_tl = hp(t_lo); m_cnt = '0; m_er = 1'b0;
    end else if (e) begin
      if (dt >= m_tl) begin
        if (dt > m_tl) m_er = 1'b1;
        m_cv = ~m_cv;
        if (m_cv) begin
          m_tl  = hp(t_hi);
          m_cnt = m_cnt + 1;
        end else begin
          m_tl = hp(t_lo);
        end
      end else begin
        m_tl = m_tl - dt;
      end
    end
    ex.dt_req   = e ? m_tl : IDLE;
    ex.clk_val  = m_cv;
    ex.edge_cnt = m_cnt;
    ex.err      = m_er;
    sb.push_back(ex);
    @(posedge emu_clk);
    #1;
    emu_rst = 1'b0;
    ex = sb.pop_front();
    got = '{dt_req: ts.dt_req, clk_val: clk_val, edge_cnt: edge_cnt, err: err};
    n_tests++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL state: got dt_req=%0d clk=%0b cnt=%0d err=%0b expected dt_req=%0d clk=%0b cnt=%0d err=%0b",
               got.dt_req, got.clk_val, got.edge_cnt, got.err,
               ex.dt_req, ex.clk_val, ex.edge_cnt, ex.err);
    end
  endtask

  task automatic test_reset();
    t_lo = 27'd10; t_hi = 27'd6;
    step(1'b1, 1'b0, '0);
    n_tests++;
    if (ts.dt_req !== IDLE || clk_val !== 1'b0 || edge_cnt !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got dt_req=%0d clk=%0b cnt=%0d err=%0b expected %0d 0 0 0",
               ts.dt_req, clk_val, edge_cnt, err, IDLE);
    end
  endtask

  task automatic test_exact_steps();
    logic [DTW-1:0] exp_dt [4] = '{27'd6, 27'd10, 27'd6, 27'd10};
    logic           exp_cv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [CW-1:0]  exp_ct [4] = '{32'd1, 32'd1, 32'd2, 32'd2};
    en = 1'b1;
    #1;
    n_tests++;
    if (ts.dt_req !== 27'd10) begin
      n_fail++;
      $display("FAIL exact_first_req: got %0d expected 10", ts.dt_req);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, m_tl);
      n_tests++;
      if (ts.dt_req !== exp_dt[i] || clk_val !== exp_cv[i] || edge_cnt !== exp_ct[i]) begin
        n_fail++;
        $display("FAIL exact_seq[%0d]: got dt_req=%0d clk=%0b cnt=%0d expected %0d %0b %0d",
                 i, ts.dt_req, clk_val, edge_cnt, exp_dt[i], exp_cv[i], exp_ct[i]);
      end
    end
  endtask

  task automatic test_partial_steps();
    logic [DTW-1:0] exp_dt [3] = '{27'd7, 27'd4, 27'd1};
    t_lo = 27'd10; t_hi = 27'd6;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 27'd3);
      n_tests++;
      if (ts.dt_req !== exp_dt[i]) begin
        n_fail++;
        $display("FAIL partial[%0d]: got %0d expected %0d", i, ts.dt_req, exp_dt[i]);
      end
    end
    step(1'b0, 1'b1, 27'd1);
    n_tests++;
    if (clk_val !== 1'b1 || ts.dt_req !== 27'd6 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_edge: got clk=%0b dt_req=%0d err=%0b expected 1 6 0",
               clk_val, ts.dt_req, err);
    end
  endtask

  task automatic test_overshoot();
    step(1'b0, 1'b1, 27'd2);          // high phase 6 -> 4
    step(1'b0, 1'b1, 27'd9);          // overshoot
    n_tests++;
    if (err !== 1'b1 || clk_val !== 1'b0 || ts.dt_req !== 27'd10) begin
      n_fail++;
      $display("FAIL overshoot: got err=%0b clk=%0b dt_req=%0d expected 1 0 10",
               err, clk_val, ts.dt_req);
    end
    step(1'b0, 1'b1, 27'd4);
    step(1'b0, 1'b1, 27'd6);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %0b expected 1", err);
    end
    step(1'b1, 1'b1, '0);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %0b expected 0", err);
    end
  endtask

  task automatic test_enable_hold();
    step(1'b0, 1'b1, 27'd5);          // 10 -> 5
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 27'd2);
      n_tests++;
      if (ts.dt_req !== IDLE || ts.cke !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled[%0d]: got dt_req=%0d cke=%0b expected %0d 0",
                 i, ts.dt_req, ts.cke, IDLE);
      end
    end
    en = 1'b1;
    ts.emu_dt = '0;
    #1;
    n_tests++;
    if (ts.dt_req !== 27'd5) begin
      n_fail++;
      $display("FAIL resume: got %0d expected 5", ts.dt_req);
    end
    step(1'b0, 1'b1, '0);             // zero step is legal and changes nothing
  endtask

  task automatic test_zero_period();
    t_hi = '0; t_lo = '0;
    step(1'b1, 1'b1, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 27'd1);
      n_tests++;
      if (ts.dt_req !== 27'd1 || clk_val !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL zero_period[%0d]: got dt_req=%0d clk=%0b expected 1 %0b",
                 i, ts.dt_req, clk_val, ((i % 2) == 0));
      end
    end
  endtask

  task automatic test_reload_and_reset();
    t_hi = 27'd6; t_lo = 27'd10;
    step(1'b1, 1'b1, '0);
    step(1'b0, 1'b1, 27'd2);          // low phase 10 -> 8
    t_hi = 27'd20;
    step(1'b0, 1'b1, 27'd7);          // 8 -> 1, period unaffected
    step(1'b0, 1'b1, 27'd1);
    n_tests++;
    if (clk_val !== 1'b1 || ts.dt_req !== 27'd20 || edge_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL new_t_hi: got clk=%0b dt_req=%0d cnt=%0d expected 1 20 1",
               clk_val, ts.dt_req, edge_cnt);
    end
    step(1'b0, 1'b1, 27'd5);
    step(1'b1, 1'b1, 27'd3);          // mid-phase reset
    n_tests++;
    if (clk_val !== 1'b0 || ts.dt_req !== 27'd10 || edge_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got clk=%0b dt_req=%0d cnt=%0d expected 0 10 0",
               clk_val, ts.dt_req, edge_cnt);
    end
  endtask

  initial begin
    emu_rst = 1'b0; en = 1'b0; ts.emu_dt = '0;
    t_hi = '0; t_lo = '0;
    m_tl = '0; m_cv = 1'b0; m_cnt = '0; m_er = 1'b0;
    @(posedge emu_clk);
    #1;
    test_reset();
    test_exact_steps();
    test_partial_steps();
    test_overshoot();
    test_enable_hold();
    test_zero_period();
    test_reload_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
